mem_port_arbiter: RTL and testbench

- Shares the single unified ROM+RAM memory port between two requesters: the instruction-fetch (IF) unit and the load/store (LS) unit of the RISC-V core.
- Accepts one request at a time, registers it, and drives the memory port for exactly one access cycle.
- Returns the read data one cycle after the access, with a valid pulse.
- Gives LS priority, with starvation protection for IF, and blocks illegal LS accesses.

---
 rtl/mem_port_arbiter_if.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the unified memory port and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [DATA_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;

    logic                  ls_req_i;
    logic                  ls_we_i;
    logic [DATA_WIDTH-1:0] ls_addr_i;
    logic [DATA_WIDTH-1:0] ls_wdata_i;
    logic                  ls_gnt_o;
    logic                  ls_rvalid_o;
    logic [DATA_WIDTH-1:0] ls_rdata_o;
    logic                  ls_err_o;

    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  busy_o;

    modport slave (
        input  if_req_i,
        input  if_addr_i,
        output if_gnt_o,
        output if_rvalid_o,
        output if_rdata_o,
        input  ls_req_i,
        input  ls_we_i,
        input  ls_addr_i,
        input  ls_wdata_i,
        output ls_gnt_o,
        output ls_rvalid_o,
        output ls_rdata_o,
        output ls_err_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        output busy_o
    );

    modport master (
        output if_req_i,
        output if_addr_i,
        input  if_gnt_o,
        input  if_rvalid_o,
        input  if_rdata_o,
        output ls_req_i,
        output ls_we_i,
        output ls_addr_i,
        output ls_wdata_i,
        input  ls_gnt_o,
        input  ls_rvalid_o,
        input  ls_rdata_o,
        input  ls_err_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        input  busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified ROM+RAM port between instruction fetch and load/store.
// LS has priority; IF is forced through after MAX_WAIT consecutive losses.
module mem_port_arbiter #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RAM_BASE   = 32'h1001_0000,
    parameter int unsigned           MAX_WAIT   = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned          CntW   = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0]      MaxCnt = CntW'(MAX_WAIT);
    localparam logic [DATA_WIDTH-1:0] WordMask = ~DATA_WIDTH'(3);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                    owner_ls_q, owner_ls_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   ls_rdata_q, ls_rdata_d;

    logic accept;
    logic if_gnt;
    logic ls_gnt;
    logic ls_illegal;

    // Grant decision: combinational from state and the two request lines.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        accept = (state_q == StIdle) || (state_q == StResp);
        if (accept) begin
            if (bus.ls_req_i && bus.if_req_i) begin
                if (wait_cnt_q == MaxCnt) begin
                    if_gnt = 1'b1;
                end else begin
                    ls_gnt = 1'b1;
                end
            end else if (bus.ls_req_i) begin
                ls_gnt = 1'b1;
            end else if (bus.if_req_i) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Misaligned accesses and stores into ROM are rejected, never reach memory.
    always_comb begin
        ls_illegal = (bus.ls_addr_i[1:0] != 2'b00) ||
                     (bus.ls_we_i && (bus.ls_addr_i < RAM_BASE));
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        owner_ls_d = owner_ls_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;

        unique case (state_q)
            StIdle, StResp: begin
                if (if_gnt) begin
                    state_d    = StAccess;
                    wait_cnt_d = '0;
                    owner_ls_d = 1'b0;
                    addr_d     = bus.if_addr_i & WordMask;
                    wdata_d    = '0;
                    we_d       = 1'b0;
                    err_d      = 1'b0;
                end else if (ls_gnt) begin
                    state_d    = StAccess;
                    if (bus.if_req_i && (wait_cnt_q != MaxCnt)) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    owner_ls_d = 1'b1;
                    addr_d     = bus.ls_addr_i;
                    wdata_d    = bus.ls_wdata_i;
                    we_d       = bus.ls_we_i;
                    err_d      = ls_illegal;
                end else begin
                    state_d = StIdle;
                end
            end
            StAccess: begin
                state_d = StResp;
                if (owner_ls_q) begin
                    ls_rdata_d = err_q ? '0 : bus.mem_rdata_i;
                end else begin
                    if_rdata_d = err_q ? '0 : bus.mem_rdata_i;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            owner_ls_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            owner_ls_q <= owner_ls_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Write enable is decoded from state so an async reset kills it immediately.
    assign bus.mem_we_o    = (state_q == StAccess) && we_q && !err_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.busy_o      = (state_q == StAccess);

    assign bus.if_gnt_o    = if_gnt;
    assign bus.if_rvalid_o = (state_q == StResp) && !owner_ls_q;
    assign bus.if_rdata_o  = if_rdata_q;

    assign bus.ls_gnt_o    = ls_gnt;
    assign bus.ls_rvalid_o = (state_q == StResp) && owner_ls_q;
    assign bus.ls_err_o    = (state_q == StResp) && owner_ls_q && err_q;
    assign bus.ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge, outputs
// are checked 1 time unit later, well away from the rising edge.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if #(.DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH(32),
        .RAM_BASE  (32'h1001_0000),
        .MAX_WAIT  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_ls;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.ls_req_i    = 1'b0;
        bus.ls_we_i     = 1'b0;
        bus.ls_addr_i   = '0;
        bus.ls_wdata_i  = '0;
        bus.mem_rdata_i = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        chk("rst_ls_gnt", 32'(bus.ls_gnt_o), 32'd0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        chk("rst_ls_rvalid", 32'(bus.ls_rvalid_o), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'd0);
        reset = 1'b0;

        // IF fetch: grant, access, response
        @(negedge clk);
        bus.if_req_i    = 1'b1;
        bus.if_addr_i   = 32'h0040_0004;
        bus.mem_rdata_i = 32'h0000_0013;
        #1;
        chk("if_gnt_c0", 32'(bus.if_gnt_o), 32'd1);
        chk("if_ls_gnt_c0", 32'(bus.ls_gnt_o), 32'd0);
        @(negedge clk);
        bus.if_req_i = 1'b0;
        #1;
        chk("if_busy_c1", 32'(bus.busy_o), 32'd1);
        chk("if_addr_c1", bus.mem_addr_o, 32'h0040_0004);
        chk("if_we_c1", 32'(bus.mem_we_o), 32'd0);
        chk("if_rvalid_c1", 32'(bus.if_rvalid_o), 32'd0);
        @(negedge clk);
        #1;
        chk("if_rvalid_c2", 32'(bus.if_rvalid_o), 32'd1);
        chk("if_rdata_c2", bus.if_rdata_o, 32'h0000_0013);
        chk("if_busy_c2", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        #1;
        chk("if_rvalid_c3", 32'(bus.if_rvalid_o), 32'd0);
        chk("if_rdata_hold", bus.if_rdata_o, 32'h0000_0013);

        // Legal LS store
        bus.ls_req_i   = 1'b1;
        bus.ls_we_i    = 1'b1;
        bus.ls_addr_i  = 32'h1001_0008;
        bus.ls_wdata_i = 32'hDEAD_BEEF;
        #1;
        chk("st_gnt", 32'(bus.ls_gnt_o), 32'd1);
        chk("st_we_grant_cycle", 32'(bus.mem_we_o), 32'd0);
        @(negedge clk);
        bus.ls_req_i = 1'b0;
        #1;
        chk("st_we_access", 32'(bus.mem_we_o), 32'd1);
        chk("st_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
        chk("st_addr", bus.mem_addr_o, 32'h1001_0008);
        @(negedge clk);
        #1;
        chk("st_we_resp", 32'(bus.mem_we_o), 32'd0);
        chk("st_rvalid", 32'(bus.ls_rvalid_o), 32'd1);
        chk("st_err", 32'(bus.ls_err_o), 32'd0);

        // Store into ROM, then misaligned load, back to back
        @(negedge clk);
        bus.mem_rdata_i = 32'hCAFE_F00D;
        bus.ls_req_i    = 1'b1;
        bus.ls_we_i     = 1'b1;
        bus.ls_addr_i   = 32'h0040_0000;
        bus.ls_wdata_i  = 32'h1111_2222;
        #1;
        chk("rom_st_gnt", 32'(bus.ls_gnt_o), 32'd1);
        @(negedge clk);
        bus.ls_req_i = 1'b0;
        #1;
        chk("rom_st_we", 32'(bus.mem_we_o), 32'd0);
        chk("rom_st_busy", 32'(bus.busy_o), 32'd1);
        @(negedge clk);
        bus.ls_req_i  = 1'b1;
        bus.ls_we_i   = 1'b0;
        bus.ls_addr_i = 32'h1001_0002;
        #1;
        chk("rom_st_rvalid", 32'(bus.ls_rvalid_o), 32'd1);
        chk("rom_st_err", 32'(bus.ls_err_o), 32'd1);
        chk("rom_st_rdata", bus.ls_rdata_o, 32'd0);
        chk("mis_ld_gnt_resp", 32'(bus.ls_gnt_o), 32'd1);
        @(negedge clk);
        bus.ls_req_i = 1'b0;
        #1;
        chk("mis_ld_we", 32'(bus.mem_we_o), 32'd0);
        chk("mis_ld_err_access", 32'(bus.ls_err_o), 32'd0);
        @(negedge clk);
        #1;
        chk("mis_ld_rvalid", 32'(bus.ls_rvalid_o), 32'd1);
        chk("mis_ld_err", 32'(bus.ls_err_o), 32'd1);
        chk("mis_ld_rdata", bus.ls_rdata_o, 32'd0);

        // Simultaneous requests in IDLE
        @(negedge clk);
        bus.mem_rdata_i = 32'h0000_0093;
        bus.if_req_i    = 1'b1;
        bus.if_addr_i   = 32'h0040_0008;
        bus.ls_req_i    = 1'b1;
        bus.ls_we_i     = 1'b0;
        bus.ls_addr_i   = 32'h1001_0010;
        #1;
        chk("sim_ls_gnt", 32'(bus.ls_gnt_o), 32'd1);
        chk("sim_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        @(negedge clk);
        bus.ls_req_i = 1'b0;
        #1;
        chk("sim_access_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        @(negedge clk);
        #1;
        chk("sim_resp_ls_rvalid", 32'(bus.ls_rvalid_o), 32'd1);
        chk("sim_resp_ls_rdata", bus.ls_rdata_o, 32'h0000_0093);
        chk("sim_resp_if_gnt", 32'(bus.if_gnt_o), 32'd1);
        @(negedge clk);
        bus.if_req_i = 1'b0;
        #1;
        chk("sim_if_access_addr", bus.mem_addr_o, 32'h0040_0008);
        chk("sim_if_rvalid_early", 32'(bus.if_rvalid_o), 32'd0);
        @(negedge clk);
        #1;
        chk("sim_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
        chk("sim_if_rdata", bus.if_rdata_o, 32'h0000_0093);

        // Continuous contention: four LS grants, then one forced IF grant
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h0040_0010;
        bus.ls_req_i   = 1'b1;
        bus.ls_we_i    = 1'b0;
        bus.ls_addr_i  = 32'h1001_0020;
        #1;
        for (int k = 0; k < 10; k++) begin
            exp_ls = ((k % 5) != 4);
            chk("arb_ls_gnt", 32'(bus.ls_gnt_o), 32'(exp_ls));
            chk("arb_if_gnt", 32'(bus.if_gnt_o), 32'(!exp_ls));
            @(negedge clk);
            #1;
            chk("arb_access_nognt", 32'({bus.if_gnt_o, bus.ls_gnt_o}), 32'd0);
            @(negedge clk);
            if (k == 9) begin
                bus.if_req_i = 1'b0;
                bus.ls_req_i = 1'b0;
            end
            #1;
        end
        chk("arb_last_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);

        // Reset during the ACCESS cycle of a store
        @(negedge clk);
        bus.ls_req_i   = 1'b1;
        bus.ls_we_i    = 1'b1;
        bus.ls_addr_i  = 32'h1001_0030;
        bus.ls_wdata_i = 32'h1234_5678;
        #1;
        chk("rst_st_gnt", 32'(bus.ls_gnt_o), 32'd1);
        @(negedge clk);
        bus.ls_req_i = 1'b0;
        #1;
        chk("rst_st_we_before", 32'(bus.mem_we_o), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_st_we_after", 32'(bus.mem_we_o), 32'd0);
        chk("rst_st_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_if_rdata_cleared", bus.if_rdata_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_no_rvalid0", 32'(bus.ls_rvalid_o), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_no_rvalid1", 32'(bus.ls_rvalid_o), 32'd0);
        chk("rst_idle_busy", 32'(bus.busy_o), 32'd0);

        @(negedge clk);
        bus.mem_rdata_i = 32'h0000_0293;
        bus.if_req_i    = 1'b1;
        bus.if_addr_i   = 32'h0040_000C;
        #1;
        chk("post_if_gnt", 32'(bus.if_gnt_o), 32'd1);
        @(negedge clk);
        bus.if_req_i = 1'b0;
        #1;
        chk("post_if_addr", bus.mem_addr_o, 32'h0040_000C);
        chk("post_if_busy", 32'(bus.busy_o), 32'd1);
        @(negedge clk);
        #1;
        chk("post_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
        chk("post_if_rdata", bus.if_rdata_o, 32'h0000_0293);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
